// File: rtl/booth_r4_seq_mult.sv
`default_nettype none
// ============================================================================
// Module   : booth_r4_seq_mult
// Brief    : Sequential radix-4 Booth multiplier, one digit per cycle, with
//            signed/unsigned mode, valid/ready handshakes and early termination.
// Revision : 1.0 - initial release
// ============================================================================
module booth_r4_seq_mult #(
    parameter int WIDTH      = 8,
    parameter int EARLY_TERM = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     mc,
    input  logic [WIDTH-1:0]     mp,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    localparam int c_nmax = WIDTH / 2 + 1;
    localparam int c_mpw  = 2 * c_nmax + 1;
    localparam int c_hw   = WIDTH + 3;
    localparam int c_aw   = c_hw + 2 * c_nmax;
    localparam int c_cw   = $clog2(c_nmax + 1);

    if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_width_check
        $error("booth_r4_seq_mult: WIDTH must be even and >= 4");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [WIDTH:0]        r_mc;
    logic [c_mpw-1:0]      r_mp;
    logic                  r_sgn;
    logic [c_cw-1:0]       r_cnt;
    logic [c_aw-1:0]       r_acc;
    logic [2*WIDTH-1:0]    r_product;

    logic [2:0]            w_b;
    logic                  w_neg;
    logic                  w_one;
    logic                  w_two;
    logic [WIDTH+1:0]      w_mag;
    logic [c_hw-1:0]       w_pp_hi;
    logic [c_aw-1:0]       w_inc;
    logic signed [c_aw-1:0] w_sum;
    logic signed [c_aw-1:0] w_acc_next;
    logic [c_mpw-1:0]      w_mp_next;
    logic                  w_last;
    logic                  w_et;
    logic                  w_fin;
    logic [c_cw-1:0]       w_shamt;
    logic signed [c_aw-1:0] w_aligned;
    logic                  w_accept;

    // Booth digit decode of the current 3-bit window
    assign w_b   = r_mp[2:0];
    assign w_neg = w_b[2];
    assign w_one = w_b[1] ^ w_b[0];
    assign w_two = (w_b[2] & ~w_b[1] & ~w_b[0]) | (~w_b[2] & w_b[1] & w_b[0]);
    assign w_mag = w_one ? {r_mc[WIDTH], r_mc} :
                   w_two ? {r_mc, 1'b0} : '0;

    // Negation is invert here; the +1 enters the sum through w_inc
    assign w_pp_hi = w_neg ? ~{w_mag[WIDTH+1], w_mag} : {w_mag[WIDTH+1], w_mag};
    assign w_inc   = {{(c_hw-1){1'b0}}, w_neg, {(2*c_nmax){1'b0}}};
    assign w_sum   = r_acc + {w_pp_hi, {(2*c_nmax){1'b0}}} + w_inc;
    assign w_acc_next = w_sum >>> 2;
    assign w_mp_next  = {{2{r_mp[c_mpw-1]}}, r_mp[c_mpw-1:2]};

    assign w_last  = (r_cnt == (r_sgn ? c_cw'(c_nmax - 2) : c_cw'(c_nmax - 1)));
    assign w_et    = (EARLY_TERM != 0) && ((w_mp_next == '0) || (&w_mp_next));
    assign w_fin   = w_last || w_et;

    // Digits are always inserted at the top, so undo the shifts not yet taken
    assign w_shamt   = c_cw'(c_nmax - 1) - r_cnt;
    assign w_aligned = w_acc_next >>> {w_shamt, 1'b0};

    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign product   = r_product;
    assign w_accept  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_state_next = ST_RUN;
            ST_RUN:  if (w_fin)     w_state_next = ST_DONE;
            ST_DONE: if (out_ready) w_state_next = ST_IDLE;
            default:                w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mc      <= '0;
            r_mp      <= '0;
            r_sgn     <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_product <= '0;
        end else if ((r_state == ST_IDLE) && w_accept) begin
            r_mc  <= {signed_mode & mc[WIDTH-1], mc};
            r_mp  <= {{2{signed_mode & mp[WIDTH-1]}}, mp, 1'b0};
            r_sgn <= signed_mode;
            r_cnt <= '0;
            r_acc <= '0;
        end else if (r_state == ST_RUN) begin
            r_acc <= w_acc_next;
            r_mp  <= w_mp_next;
            r_cnt <= r_cnt + c_cw'(1);
            if (w_fin) begin
                r_product <= (2*WIDTH)'(w_aligned);
            end
        end
    end
endmodule
`default_nettype wire
